fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_pkg.sv | 8 +
 rtl/fifo_rd_skid.sv | 35 +++
 rtl/fifo_reader.sv | 117 +++++++++++
 tb/tb_fifo_reader.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths, FIFO depth and reader state encoding
// No ports; imported by the reader and its skid buffer.
package fifo_pkg;
    localparam int DATA_W     = 32;
    localparam int LEN_W      = 8;
    localparam int FIFO_DEPTH = 128;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: two-entry in-order buffer between FIFO read data and the output stream
// Ports: clk/rst (async, active-high); push+data_in write a word; pop removes the head;
// count is the occupancy (0..2); head is the oldest word (0 after reset).
module fifo_rd_skid #(
    parameter int DATA_W = fifo_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head
);
    import fifo_pkg::*;
    logic [DATA_W-1:0] tail;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (pop && count == 2'd2)
                head <= tail;
            // the new word becomes head if it would be the only one left, else it queues behind
            if (push) begin
                if (count == 2'd0 || (count == 2'd1 && pop))
                    head <= data_in;
                else
                    tail <= data_in;
            end
        end
    end
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: burst reader that pops words from a FIFO and streams them downstream
// Ports: clk/rst (async, active-high); start+burst_len launch a burst from IDLE;
// empty/read_flag/data_read/err_read face the FIFO (data arrives one cycle after a pop);
// out_data/out_valid/out_ready is the output stream; busy/done/error report status;
// words_read/checksum count and sum the delivered words.
module fifo_reader #(
    parameter int DATA_W = fifo_pkg::DATA_W,
    parameter int LEN_W  = fifo_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              empty,
    output logic              read_flag,
    input  logic [DATA_W-1:0] data_read,
    input  logic              err_read,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  words_read,
    output logic [DATA_W-1:0] checksum
);
    import fifo_pkg::*;

    state_t           state, state_nx;
    logic [LEN_W-1:0] len_q, issued;
    logic [1:0]       count, occ;
    logic             in_flight, push, cap_err, xfer, accept, room;

    assign out_valid = count != 2'd0;
    assign xfer      = out_valid && out_ready;
    assign push      = in_flight && !err_read;
    assign cap_err   = in_flight && err_read;
    assign accept    = state == IDLE && start;
    // the word leaving this cycle frees its slot, which keeps one pop in flight at full rate
    assign occ       = count - {1'b0, xfer} + {1'b0, in_flight};
    assign room      = occ < 2'd2;

    fifo_rd_skid #(.DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .data_in (data_read),
        .pop     (xfer),
        .count   (count),
        .head    (out_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        read_flag = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = (burst_len == '0) ? DONE : READ;
            end
            READ: begin
                busy      = 1'b1;
                read_flag = !empty && !cap_err && room && issued < len_q;
                if (cap_err || (read_flag && issued == len_q - LEN_W'(1)))
                    state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!in_flight && count == 2'd0)
                    state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            issued     <= '0;
            in_flight  <= 1'b0;
            error      <= 1'b0;
            words_read <= '0;
            checksum   <= '0;
        end else begin
            in_flight <= read_flag;
            if (accept) begin
                len_q      <= burst_len;
                issued     <= '0;
                error      <= 1'b0;
                words_read <= '0;
                checksum   <= '0;
            end else begin
                if (read_flag)
                    issued <= issued + LEN_W'(1);
                if (cap_err)
                    error <= 1'b1;
                if (xfer) begin
                    words_read <= words_read + LEN_W'(1);
                    checksum   <= checksum + out_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: randomized self-checking bench for fifo_reader against a queue-based FIFO model
module tb_fifo_reader;
    localparam int DW = 32;
    localparam int LW = 8;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, empty = 1'b1, err_read = 1'b0, out_ready = 1'b1;
    logic read_flag, out_valid, busy, done, error;
    logic [LW-1:0] burst_len = '0, words_read;
    logic [DW-1:0] data_read = '0, out_data, checksum;

    int checks = 0, errors = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] fill[$];
    int pop_idx = 0, err_pop = -1;
    logic hold_empty = 1'b0, rf;

    logic [DW-1:0] obs_q[$];
    int obs_cyc[$];
    int pops, done_cnt, done_cyc, first_valid_cyc, unstable, rd_while_empty, rd_after_err, max_out, finished;
    logic busy_before_done, busy_at_done, busy_end, err_end;
    logic [LW-1:0] wr_end;
    logic [DW-1:0] cs_end;
    int ready_pct, empty_pct, stall_cycles, gap_after, gap_cycles, start_hold;

    fifo_reader #(.DATA_W(DW), .LEN_W(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .empty      (empty),
        .read_flag  (read_flag),
        .data_read  (data_read),
        .err_read   (err_read),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .words_read (words_read),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // FIFO model: a pop seen in a cycle returns the queue head during the next cycle
    always begin
        @(negedge clk);
        rf = read_flag;
        @(posedge clk);
        #2;
        if (rf && fq.size() > 0) begin
            data_read = fq.pop_front();
            err_read  = (pop_idx == err_pop);
            pop_idx++;
        end else begin
            data_read = $urandom;
            err_read  = 1'b0;
        end
        empty = hold_empty || fq.size() == 0;
    end

    task automatic defaults;
        ready_pct = 100; empty_pct = 0; stall_cycles = 0;
        gap_after = -1; gap_cycles = 0; start_hold = 1; err_pop = -1;
    endtask

    task automatic load_fifo(input int n);
        fill.delete();
        fq.delete();
        for (int i = 0; i < n; i++) fill.push_back($urandom);
        fq = fill;
    endtask

    task automatic run_burst(input logic [LW-1:0] len, input int budget);
        int cyc = 0, end_cyc = budget, gap_start = -1, hold_left = start_hold;
        logic pv = 1'b0, pr = 1'b1, prev_busy = 1'b0;
        logic [DW-1:0] pd = '0;
        obs_q.delete(); obs_cyc.delete();
        pops = 0; done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; unstable = 0;
        rd_while_empty = 0; rd_after_err = 0; max_out = 0; finished = 0;
        busy_before_done = 1'b0; busy_at_done = 1'b1; busy_end = 1'b1;
        @(posedge clk); #1;
        pop_idx = 0; burst_len = len; start = 1'b1; hold_empty = 1'b0;
        out_ready = (stall_cycles == 0) && (int'($urandom_range(0, 99)) < ready_pct);
        while (cyc <= end_cyc && cyc < budget) begin
            @(negedge clk);
            if (read_flag) begin
                pops++;
                if (empty) rd_while_empty++;
                if (error) rd_after_err++;
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (pv && !pr && (!out_valid || out_data !== pd)) unstable++;
            if (out_valid && out_ready) begin
                obs_q.push_back(out_data);
                obs_cyc.push_back(cyc);
            end
            if (pops - obs_q.size() > max_out) max_out = pops - obs_q.size();
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc; end_cyc = cyc + 1;
                    busy_before_done = prev_busy; busy_at_done = busy;
                end
            end
            if (cyc == end_cyc) begin
                finished = 1; busy_end = busy;
                wr_end = words_read; cs_end = checksum; err_end = error;
            end
            if (gap_after >= 0 && gap_start < 0 && pops >= gap_after) gap_start = cyc + 1;
            pv = out_valid; pr = out_ready; pd = out_data; prev_busy = busy;
            @(posedge clk); #1;
            if (hold_left > 0) begin
                hold_left--;
                start = hold_left > 0;
                burst_len = len + LW'(3);
            end
            out_ready = !(stall_cycles > 0 && (first_valid_cyc < 0 || cyc + 1 < first_valid_cyc + stall_cycles))
                        && (int'($urandom_range(0, 99)) < ready_pct);
            hold_empty = (int'($urandom_range(0, 99)) < empty_pct)
                         || (gap_start >= 0 && cyc + 1 < gap_start + gap_cycles);
            cyc++;
        end
        start = 1'b0; out_ready = 1'b1; hold_empty = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({read_flag, out_valid, busy, done, error} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {read_flag, out_valid, busy, done, error});
        end
        checks++;
        if (words_read !== '0) begin errors++; $display("FAIL reset_words: got %0d want 0", words_read); end
        checks++;
        if (checksum !== '0) begin errors++; $display("FAIL reset_checksum: got %h want 0", checksum); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [DW-1:0] exp_w[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        int bad = 0;
        defaults();
        fill.delete();
        for (int i = 0; i < 4; i++) fill.push_back(exp_w[i]);
        fq = fill;
        run_burst(8'd4, 100);
        checks++;
        if (finished !== 1) begin errors++; $display("FAIL basic_timeout: done not seen"); end
        if (obs_q.size() != 4) bad = 1;
        else for (int i = 0; i < 4; i++) if (obs_q[i] !== exp_w[i]) bad = 1;
        checks++;
        if (bad) begin errors++; $display("FAIL basic_order: got %0d words want 4 in order 11,22,33,44", obs_q.size()); end
        checks++;
        if (obs_q.size() == 4 && obs_cyc[3] - obs_cyc[0] != 3) begin
            errors++; $display("FAIL basic_throughput: span %0d cycles want 3", obs_cyc[3] - obs_cyc[0]);
        end
        checks++;
        if (first_valid_cyc - 1 != 2) begin
            errors++; $display("FAIL basic_latency: got %0d cycles want 2", first_valid_cyc - 1);
        end
        checks++;
        if (wr_end !== 8'd4) begin errors++; $display("FAIL basic_words: got %0d want 4", wr_end); end
        checks++;
        if (cs_end !== 32'hAA) begin errors++; $display("FAIL basic_checksum: got %h want aa", cs_end); end
        checks++;
        if (done_cnt != 1 || busy_at_done !== 1'b0 || busy_before_done !== 1'b1) begin
            errors++; $display("FAIL basic_done: pulses %0d busy_at %b busy_before %b want 1 0 1", done_cnt, busy_at_done, busy_before_done);
        end
    endtask

    task automatic test_stall;
        int bad = 0;
        defaults();
        stall_cycles = 5;
        load_fifo(6);
        run_burst(8'd3, 100);
        if (obs_q.size() != 3) bad = 1;
        else for (int i = 0; i < 3; i++) if (obs_q[i] !== fill[i]) bad = 1;
        checks++;
        if (!finished || bad) begin errors++; $display("FAIL stall_order: got %0d words finished %0d want 3 in order", obs_q.size(), finished); end
        checks++;
        if (max_out > 2) begin errors++; $display("FAIL stall_outstanding: got %0d want <=2", max_out); end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL stall_stable: %0d unstable cycles want 0", unstable); end
        checks++;
        if (wr_end !== 8'd3) begin errors++; $display("FAIL stall_words: got %0d want 3", wr_end); end
    endtask

    task automatic test_empty_gap;
        int bad = 0;
        defaults();
        gap_after = 2; gap_cycles = 10;
        load_fifo(8);
        run_burst(8'd5, 100);
        if (obs_q.size() != 5) bad = 1;
        else for (int i = 0; i < 5; i++) if (obs_q[i] !== fill[i]) bad = 1;
        checks++;
        if (!finished || bad) begin errors++; $display("FAIL gap_order: got %0d words finished %0d want 5", obs_q.size(), finished); end
        checks++;
        if (rd_while_empty != 0) begin errors++; $display("FAIL gap_read_empty: %0d pops while empty want 0", rd_while_empty); end
        checks++;
        if (wr_end !== 8'd5 || pops != 5) begin errors++; $display("FAIL gap_words: words %0d pops %0d want 5 5", wr_end, pops); end
    endtask

    task automatic test_zero_len;
        defaults();
        load_fifo(4);
        run_burst(8'd0, 20);
        checks++;
        if (pops != 0) begin errors++; $display("FAIL zero_pops: got %0d want 0", pops); end
        checks++;
        if (done_cyc != 1 || done_cnt != 1) begin errors++; $display("FAIL zero_done: at %0d count %0d want 1 1", done_cyc, done_cnt); end
        checks++;
        if (wr_end !== '0 || cs_end !== '0) begin errors++; $display("FAIL zero_totals: words %0d sum %h want 0 0", wr_end, cs_end); end
    endtask

    task automatic test_error;
        logic [DW-1:0] s;
        defaults();
        err_pop = 2;
        load_fifo(8);
        s = fill[0] + fill[1];
        run_burst(8'd6, 100);
        checks++;
        if (!finished || done_cnt != 1) begin errors++; $display("FAIL err_done: finished %0d pulses %0d want 1 1", finished, done_cnt); end
        checks++;
        if (err_end !== 1'b1) begin errors++; $display("FAIL err_flag: got %b want 1", err_end); end
        checks++;
        if (wr_end !== 8'd2 || cs_end !== s) begin errors++; $display("FAIL err_totals: words %0d sum %h want 2 %h", wr_end, cs_end, s); end
        checks++;
        if (obs_q.size() != 2 || obs_q[0] !== fill[0] || obs_q[1] !== fill[1]) begin
            errors++; $display("FAIL err_order: got %0d words want first 2 FIFO words", obs_q.size());
        end
        checks++;
        if (pops != 3 || rd_after_err != 0) begin errors++; $display("FAIL err_pops: pops %0d after_err %0d want 3 0", pops, rd_after_err); end
        err_pop = -1;
    endtask

    task automatic test_ignore_start;
        defaults();
        start_hold = 3;
        ready_pct = 60;
        load_fifo(12);
        run_burst(8'd4, 200);
        checks++;
        if (!finished || pops != 4 || wr_end !== 8'd4 || done_cnt != 1) begin
            errors++; $display("FAIL busy_start: pops %0d words %0d pulses %0d want 4 4 1", pops, wr_end, done_cnt);
        end
        start_hold = 2;
        run_burst(8'd0, 20);
        checks++;
        if (pops != 0 || done_cnt != 1 || busy_end !== 1'b0) begin
            errors++; $display("FAIL done_start: pops %0d pulses %0d busy %b want 0 1 0", pops, done_cnt, busy_end);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 10; it++) begin
            int len, n, bad;
            logic [DW-1:0] s;
            defaults();
            len = $urandom_range(1, 12);
            ready_pct = $urandom_range(30, 100);
            empty_pct = $urandom_range(0, 40);
            err_pop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            load_fifo(len + 4);
            n = (err_pop >= 0) ? err_pop : len;
            s = '0;
            for (int i = 0; i < n; i++) s += fill[i];
            run_burst(LW'(len), 400);
            bad = (obs_q.size() != n);
            if (!bad) for (int i = 0; i < n; i++) if (obs_q[i] !== fill[i]) bad = 1;
            checks++;
            if (!finished || bad) begin errors++; $display("FAIL rand%0d_order: got %0d words finished %0d want %0d", it, obs_q.size(), finished, n); end
            checks++;
            if (wr_end !== LW'(n) || cs_end !== s) begin
                errors++; $display("FAIL rand%0d_totals: words %0d sum %h want %0d %h", it, wr_end, cs_end, n, s);
            end
            checks++;
            if (err_end !== (err_pop >= 0)) begin errors++; $display("FAIL rand%0d_error: got %b want %b", it, err_end, err_pop >= 0); end
            checks++;
            if (pops != ((err_pop >= 0) ? err_pop + 1 : len)) begin
                errors++; $display("FAIL rand%0d_pops: got %0d want %0d", it, pops, (err_pop >= 0) ? err_pop + 1 : len);
            end
            checks++;
            if (max_out > 2 || unstable != 0 || rd_while_empty != 0 || rd_after_err != 0) begin
                errors++; $display("FAIL rand%0d_rules: outstanding %0d unstable %0d rd_empty %0d rd_err %0d want <=2 0 0 0",
                                   it, max_out, unstable, rd_while_empty, rd_after_err);
            end
            checks++;
            if (done_cnt != 1 || busy_end !== 1'b0) begin errors++; $display("FAIL rand%0d_done: pulses %0d busy %b want 1 0", it, done_cnt, busy_end); end
        end
        err_pop = -1;
    endtask

    task automatic test_reset_mid_burst;
        int cyc = 0, bad = 0;
        defaults();
        fill.delete(); fq.delete();
        for (int i = 0; i < 8; i++) fill.push_back($urandom | 32'h1);
        fq = fill;
        @(posedge clk); #1;
        pop_idx = 0; burst_len = 8'd6; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (words_read < 8'd2 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (words_read !== 8'd2 || out_valid !== 1'b1 || out_data !== fill[2]) begin
            errors++; $display("FAIL rstmid_setup: words %0d valid %b data %h want 2 1 %h", words_read, out_valid, out_data, fill[2]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({read_flag, out_valid, busy, done, error} !== 5'b0) begin
            errors++; $display("FAIL rstmid_flags: got %b want 00000", {read_flag, out_valid, busy, done, error});
        end
        checks++;
        if (words_read !== '0 || checksum !== '0 || out_data !== '0) begin
            errors++; $display("FAIL rstmid_values: words %0d sum %h data %h want 0 0 0", words_read, checksum, out_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        load_fifo(4);
        run_burst(8'd4, 100);
        if (obs_q.size() != 4) bad = 1;
        else for (int i = 0; i < 4; i++) if (obs_q[i] !== fill[i]) bad = 1;
        checks++;
        if (!finished || bad || wr_end !== 8'd4) begin
            errors++; $display("FAIL rstmid_clean: got %0d words total %0d finished %0d want 4 4 1", obs_q.size(), wr_end, finished);
        end
    endtask

    initial begin
        defaults();
        test_reset();
        test_basic();
        test_stall();
        test_empty_gap();
        test_zero_len();
        test_error();
        test_ignore_start();
        test_random();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
